// File: rtl/gpio_pkg.sv
// gpio_pkg
// Shared constants for the GPIO/timer responder: register indices within the
// 8-word window (selected by daddr[4:2]) and bit positions inside TCTRL.

package gpio_pkg;

    localparam logic [2:0] GPIO_LED   = 3'd0;
    localparam logic [2:0] GPIO_SW    = 3'd1;
    localparam logic [2:0] GPIO_EDGE  = 3'd2;
    localparam logic [2:0] GPIO_TCTRL = 3'd3;
    localparam logic [2:0] GPIO_TCNT  = 3'd4;
    localparam logic [2:0] GPIO_TCMP  = 3'd5;

    localparam int TCTRL_EN    = 0;
    localparam int TCTRL_MATCH = 1;

endpackage

// File: rtl/input_debouncer.sv
// input_debouncer
// Brings an asynchronous switch vector into the CLK domain and only accepts a
// new value once it has been unchanged for DEBOUNCE_CYCLES consecutive cycles.
// The whole vector shares one candidate and one counter, so a change on any
// bit restarts the stability window for every bit.
//
// Ports:
//   CLK       in   system clock
//   RESET     in   asynchronous reset, active-high
//   sw_async  in   raw switch inputs [WIDTH]
//   stable    out  debounced switch value [WIDTH]

module input_debouncer #(
    parameter int WIDTH           = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] sw_async,
    output logic [WIDTH-1:0] stable
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sw_sync;
    logic [WIDTH-1:0] candidate_q;
    logic [CW-1:0]    cnt_q;

    assign sw_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= sw_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Counter saturates at CNT_LAST; stable keeps reloading the same
    // candidate while it stays there.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            candidate_q <= '0;
            cnt_q       <= '0;
            stable      <= '0;
        end else if (sw_sync != candidate_q) begin
            candidate_q <= sw_sync;
            cnt_q       <= '0;
        end else if (cnt_q == CNT_LAST) begin
            stable      <= candidate_q;
        end else begin
            cnt_q       <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/gpio_responder.sv
// gpio_responder
// Memory-mapped GPIO/timer responder on the data-memory bus. LEDs, debounced
// switches, sticky switch rising-edge flags and a compare-match timer.
// Read data is registered (1-cycle latency), like the data RAM.
//
// Ports:
//   CLK        in   system clock
//   RESET      in   asynchronous reset, active-high
//   daddr      in   bus address, register index = daddr[4:2]
//   mem_write  in   write strobe (window-qualified)
//   mem_read   in   read strobe (window-qualified)
//   ddata_w    in   write data
//   ddata_r    out  registered read data, valid the cycle after mem_read
//   SW         in   asynchronous board switches
//   LEDR       out  board LEDs

module gpio_responder
    import gpio_pkg::*;
#(
    parameter int DATA_SIZE       = 32,
    parameter int ADDR_SIZE       = 10,
    parameter int N_LED           = 10,
    parameter int N_SW            = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [ADDR_SIZE-1:0] daddr,
    input  logic                 mem_write,
    input  logic                 mem_read,
    input  logic [DATA_SIZE-1:0] ddata_w,
    output logic [DATA_SIZE-1:0] ddata_r,
    input  logic [N_SW-1:0]      SW,
    output logic [N_LED-1:0]     LEDR
);

    logic [2:0]           reg_idx;
    logic                 wr_led, wr_edge, wr_tctrl, wr_tcnt, wr_tcmp;

    logic [N_SW-1:0]      sw_stable;
    logic [N_SW-1:0]      sw_stable_q;
    logic [N_SW-1:0]      edge_q, edge_d;

    logic                 en_q, en_d;
    logic                 match_q, match_d;
    logic [DATA_SIZE-1:0] tcnt_q, tcnt_d;
    logic [DATA_SIZE-1:0] tcmp_q;
    logic                 tcnt_hit;

    logic [DATA_SIZE-1:0] rdata;

    // Only daddr[4:2] selects a register; the rest is don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{daddr[ADDR_SIZE-1:5], daddr[1:0]};

    assign reg_idx  = daddr[4:2];
    assign wr_led   = mem_write && (reg_idx == GPIO_LED);
    assign wr_edge  = mem_write && (reg_idx == GPIO_EDGE);
    assign wr_tctrl = mem_write && (reg_idx == GPIO_TCTRL);
    assign wr_tcnt  = mem_write && (reg_idx == GPIO_TCNT);
    assign wr_tcmp  = mem_write && (reg_idx == GPIO_TCMP);

    input_debouncer #(
        .WIDTH           (N_SW),
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .CLK      (CLK),
        .RESET    (RESET),
        .sw_async (SW),
        .stable   (sw_stable)
    );

    // Rising-edge set is OR'd in after the clear so a coincident new edge survives.
    always_comb begin
        edge_d = edge_q;
        if (wr_edge) begin
            edge_d = edge_d & ~ddata_w[N_SW-1:0];
        end
        edge_d = edge_d | (sw_stable & ~sw_stable_q);
    end

    assign tcnt_hit = (tcnt_q == tcmp_q);

    always_comb begin
        tcnt_d  = tcnt_q;
        en_d    = en_q;
        match_d = match_q;

        if (wr_tcnt) begin
            tcnt_d = ddata_w;
        end else if (en_q) begin
            tcnt_d = tcnt_hit ? '0 : tcnt_q + DATA_SIZE'(1);
        end

        if (wr_tctrl) begin
            en_d = ddata_w[TCTRL_EN];
            if (ddata_w[TCTRL_MATCH]) begin
                match_d = 1'b0;
            end
        end

        // Hardware set takes priority over a same-cycle W1C.
        if (en_q && tcnt_hit) begin
            match_d = 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_idx)
            GPIO_LED:   rdata = DATA_SIZE'(LEDR);
            GPIO_SW:    rdata = DATA_SIZE'(sw_stable);
            GPIO_EDGE:  rdata = DATA_SIZE'(edge_q);
            GPIO_TCTRL: rdata = DATA_SIZE'({match_q, en_q});
            GPIO_TCNT:  rdata = tcnt_q;
            GPIO_TCMP:  rdata = tcmp_q;
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            LEDR        <= '0;
            sw_stable_q <= '0;
            edge_q      <= '0;
            en_q        <= 1'b0;
            match_q     <= 1'b0;
            tcnt_q      <= '0;
            tcmp_q      <= '1;
            ddata_r     <= '0;
        end else begin
            if (wr_led) begin
                LEDR <= ddata_w[N_LED-1:0];
            end
            if (wr_tcmp) begin
                tcmp_q <= ddata_w;
            end
            sw_stable_q <= sw_stable;
            edge_q      <= edge_d;
            en_q        <= en_d;
            match_q     <= match_d;
            tcnt_q      <= tcnt_d;
            // rdata is built from pre-edge state, so read-during-write returns the old value.
            if (mem_read) begin
                ddata_r <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_gpio_responder.sv
module tb_gpio_responder;

    import gpio_pkg::*;

    localparam int DATA_SIZE = 32;
    localparam int ADDR_SIZE = 10;
    localparam int N_LED     = 10;
    localparam int N_SW      = 10;

    logic                 CLK = 1'b0;
    logic                 RESET;
    logic [ADDR_SIZE-1:0] daddr;
    logic                 mem_write;
    logic                 mem_read;
    logic [DATA_SIZE-1:0] ddata_w;
    logic [DATA_SIZE-1:0] ddata_r;
    logic [N_SW-1:0]      SW;
    logic [N_LED-1:0]     LEDR;

    gpio_responder #(
        .DATA_SIZE       (DATA_SIZE),
        .ADDR_SIZE       (ADDR_SIZE),
        .N_LED           (N_LED),
        .N_SW            (N_SW),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .daddr     (daddr),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .ddata_w   (ddata_w),
        .ddata_r   (ddata_r),
        .SW        (SW),
        .LEDR      (LEDR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    sb_entry_t mon_e;
    int        checks = 0;
    int        errors = 0;
    logic      rd_valid;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Read data is due one edge after the strobe; compare it on the falling edge.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) rd_valid <= 1'b0;
        else       rd_valid <= mem_read;
    end

    always @(negedge CLK) begin
        if (rd_valid) begin
            if (sb_q.size() == 0) begin
                check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                mon_e = sb_q.pop_front();
                check_val(mon_e.tag, ddata_r, mon_e.exp);
            end
        end
    end

    // Every bus task starts at posedge+1 and consumes exactly one edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic bus_access(input logic [ADDR_SIZE-1:0] a, input logic wr, input logic [31:0] d,
                              input logic rd, input logic [31:0] exp, input string tag);
        daddr     = a;
        ddata_w   = d;
        mem_write = wr;
        mem_read  = rd;
        if (rd) sb_q.push_back('{tag, exp});
        @(posedge CLK);
        #1;
        mem_write = 1'b0;
        mem_read  = 1'b0;
    endtask

    task automatic bus_write(input logic [2:0] idx, input logic [31:0] d);
        bus_access({5'd0, idx, 2'b00}, 1'b1, d, 1'b0, 32'd0, "");
    endtask

    task automatic bus_read(input logic [2:0] idx, input logic [31:0] exp, input string tag);
        bus_access({5'd0, idx, 2'b00}, 1'b0, 32'd0, 1'b1, exp, tag);
    endtask

    initial begin
        RESET     = 1'b1;
        daddr     = '0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        ddata_w   = '0;
        SW        = '0;
        #1;
        check_val("rst_ledr", 32'(LEDR), 32'd0);
        check_val("rst_ddata_r", ddata_r, 32'd0);
        #11 RESET = 1'b0;
        @(posedge CLK);
        #1;

        // Reset values through the bus
        bus_read(GPIO_TCMP,  32'hFFFF_FFFF, "rst_tcmp");
        bus_read(GPIO_TCNT,  32'd0, "rst_tcnt");
        bus_read(GPIO_TCTRL, 32'd0, "rst_tctrl");
        bus_read(GPIO_SW,    32'd0, "rst_sw");
        bus_read(GPIO_EDGE,  32'd0, "rst_edge");

        // LED register, masking, aliasing, hold, unmapped indices, RO SW
        bus_write(GPIO_LED, 32'h0000_02A5);
        check_val("ledr_after_wr", 32'(LEDR), 32'h2A5);
        bus_read(GPIO_LED, 32'h0000_02A5, "led_rd");
        idle(3);
        check_val("rd_hold", ddata_r, 32'h0000_02A5);
        bus_write(GPIO_LED, 32'hFFFF_FFFF);
        check_val("ledr_mask", 32'(LEDR), 32'h3FF);
        bus_read(GPIO_LED, 32'h0000_03FF, "led_rd_mask");
        bus_access({5'b10110, GPIO_LED, 2'b11}, 1'b0, 32'd0, 1'b1, 32'h0000_03FF, "led_alias");
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_write(GPIO_SW, 32'hFFFF_FFFF);
        bus_read(3'd6, 32'd0, "idx6_rd");
        bus_read(3'd7, 32'd0, "idx7_rd");
        bus_read(GPIO_SW, 32'd0, "sw_ro");
        bus_read(GPIO_LED, 32'h0000_03FF, "led_after_unmapped");

        // Debounce latency: new value appears on the 20th edge after the change
        SW = 10'h001;
        idle(18);
        bus_read(GPIO_SW, 32'd0, "sw_not_yet");
        bus_read(GPIO_SW, 32'd1, "sw_accepted");
        idle(5);
        bus_read(GPIO_SW,   32'd1, "sw_hold");
        bus_read(GPIO_EDGE, 32'd1, "edge0_set");
        bus_write(GPIO_EDGE, 32'd1);
        bus_read(GPIO_EDGE, 32'd0, "edge0_w1c");

        // Bounce on SW[3]: never accepted
        for (int i = 0; i < 100; i++) begin
            if (i % 5 == 0) SW[3] = ~SW[3];
            bus_read(GPIO_SW, 32'd1, "sw_bounce");
        end
        SW = 10'h009;
        idle(18);
        bus_read(GPIO_SW, 32'd1, "sw3_not_yet");
        bus_read(GPIO_SW, 32'd9, "sw3_accepted");
        idle(2);
        bus_read(GPIO_EDGE, 32'h8, "edge3_once");
        bus_write(GPIO_EDGE, 32'h8);
        bus_read(GPIO_EDGE, 32'h0, "edge3_w1c");

        // Falling edge ignored
        SW = 10'h008;
        idle(25);
        bus_read(GPIO_SW,   32'h8, "sw_fall");
        bus_read(GPIO_EDGE, 32'h0, "edge_fall_ignored");

        // W1C on the edges around the new rising edge of bit 0: set must win
        SW = 10'h009;
        idle(18);
        bus_write(GPIO_EDGE, 32'h1);
        bus_write(GPIO_EDGE, 32'h1);
        bus_read(GPIO_EDGE, 32'h1, "edge_set_wins");
        bus_read(GPIO_SW,   32'h9, "sw_rise_again");

        // Timer count 0..9, reload and MATCH
        bus_write(GPIO_TCMP, 32'd9);
        bus_write(GPIO_TCTRL, 32'd1);
        for (int k = 0; k < 10; k++) begin
            bus_read(GPIO_TCNT, 32'(k), "tcnt_run");
        end
        bus_read(GPIO_TCNT,  32'd0, "tcnt_reload");
        bus_read(GPIO_TCTRL, 32'd3, "tctrl_match");
        bus_write(GPIO_TCTRL, 32'd3);
        bus_read(GPIO_TCTRL, 32'd1, "tctrl_match_clr");

        // Hardware MATCH set coincident with W1C
        bus_write(GPIO_TCTRL, 32'd0);
        bus_write(GPIO_TCNT, 32'd0);
        bus_write(GPIO_TCMP, 32'd2);
        bus_write(GPIO_TCTRL, 32'd1);
        idle(2);
        bus_write(GPIO_TCTRL, 32'd3);
        bus_read(GPIO_TCTRL, 32'd3, "match_set_wins");
        bus_read(GPIO_TCNT,  32'd1, "tcnt_after_hit");

        // Modulo wrap when TCNT is above TCMP: no MATCH
        bus_write(GPIO_TCTRL, 32'd2);
        bus_write(GPIO_TCTRL, 32'd2);
        bus_write(GPIO_TCMP, 32'd5);
        bus_write(GPIO_TCNT, 32'hFFFF_FFFF);
        bus_write(GPIO_TCTRL, 32'd1);
        bus_read(GPIO_TCNT,  32'hFFFF_FFFF, "tcnt_pre_wrap");
        bus_read(GPIO_TCNT,  32'd0, "tcnt_wrap");
        bus_read(GPIO_TCTRL, 32'd1, "wrap_no_match");

        // Same-cycle read and write of TCNT with the timer stopped
        bus_write(GPIO_TCTRL, 32'd0);
        bus_write(GPIO_TCNT, 32'h55);
        bus_access({5'd0, GPIO_TCNT, 2'b00}, 1'b1, 32'h1234, 1'b1, 32'h55, "rw_old_value");
        bus_read(GPIO_TCNT, 32'h1234, "rw_new_value");

        // Mid-cycle async reset with the timer running
        bus_write(GPIO_TCMP, 32'd100);
        bus_write(GPIO_TCTRL, 32'd1);
        bus_write(GPIO_LED, 32'h2A5);
        bus_read(GPIO_LED, 32'h2A5, "led_pre_reset");
        idle(3);
        #2 RESET = 1'b1;
        #1;
        check_val("midrst_ledr", 32'(LEDR), 32'd0);
        check_val("midrst_ddata_r", ddata_r, 32'd0);
        #10 RESET = 1'b0;
        @(posedge CLK);
        #1;
        bus_read(GPIO_TCMP,  32'hFFFF_FFFF, "midrst_tcmp");
        bus_read(GPIO_TCNT,  32'd0, "midrst_tcnt");
        bus_read(GPIO_TCTRL, 32'd0, "midrst_tctrl");
        bus_read(GPIO_EDGE,  32'd0, "midrst_edge");
        bus_read(GPIO_SW,    32'd0, "midrst_sw");
        bus_read(GPIO_LED,   32'd0, "midrst_led");

        idle(2);
        check_val("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_responder.md
Name: gpio_responder

Overview:
Memory-mapped GPIO/timer peripheral on the data-memory bus, the responder the core's load/store path talks to when the upper address decode selects the GPIO window.
- Drives board LEDs and samples board switches through synchroniser + debouncer.
- Latches rising-edge events on switches.
- Provides a compare-match timer.
- Read data is registered with 1-cycle latency, timing-identical to the registered data RAM, so the existing read-data mux needs no change.

Parameters:
DATA_SIZE, 32, bus data width
ADDR_SIZE, 10, bus address width
N_LED, 10, LED output count (≤ DATA_SIZE)
N_SW, 10, switch input count (≤ DATA_SIZE)
SYNC_STAGES, 2, flip-flop stages in the input synchroniser (≥2)
DEBOUNCE_CYCLES, 16, consecutive stable cycles before a switch change is accepted (≥2)

Ports:
CLK  input  1  system clock, all state on rising edge
RESET  input  1  asynchronous reset, active-high
daddr  input  ADDR_SIZE  bus address; register index = daddr[4:2]
mem_write  input  1  write strobe, already qualified by window decode
mem_read  input  1  read strobe, already qualified by window decode
ddata_w  input  DATA_SIZE  write data
ddata_r  output  DATA_SIZE  registered read data, valid cycle after mem_read
SW  input  N_SW  asynchronous board switches
LEDR  output  N_LED  board LEDs

Behaviour:
- Clock and reset: one clock CLK; reset RESET is asynchronous and active-high. All registers clear immediately on RESET assertion, independent of CLK.
- Reset values:
  - ddata_r = 0, LEDR = 0, EDGE = 0.
  - TCTRL = 0, TCNT = 0, TCMP = all-ones.
  - Synchroniser, debounced value and debounce counter = 0.
- Register map (index daddr[4:2]):
  - 0 LED: RW; bits N_LED-1:0 drive LEDR directly from the flop; upper bits read 0.
  - 1 SW: RO; debounced switch value, zero-extended.
  - 2 EDGE: write-1-to-clear; sticky rising-edge flags of debounced SW.
  - 3 TCTRL: bit0 EN is RW; bit1 MATCH is sticky and write-1-to-clear; other bits read 0.
  - 4 TCNT: RW; timer count.
  - 5 TCMP: RW; compare value.
  - 6,7: read 0, writes ignored.
- daddr bits [1:0] and above bit 4 are ignored. Only word accesses are supported.
- Write: takes effect on the CLK edge where mem_write=1. Visible to a read issued the following cycle.
- Read:
  - On the edge with mem_read=1, ddata_r <= selected register's pre-edge value.
  - Latency exactly 1 cycle.
  - With mem_read=0, ddata_r holds its last value.
- Simultaneous mem_read and mem_write to the same index: the read returns the old value and the write still occurs.
- Switch path:
  - SW passes through SYNC_STAGES flops to give sw_sync.
  - Debouncer holds a candidate register and a counter (width clog2(DEBOUNCE_CYCLES)).
  - If sw_sync != candidate: candidate <= sw_sync and counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= candidate, counter holds.
  - Else counter increments.
  - Vector-wide: any bit changing restarts the count for all bits.
  - Worst-case SW-to-register latency = SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
- Edge capture:
  - EDGE[i] sets on the cycle stable[i] goes 0->1.
  - Set wins over a same-cycle write-1 clear of that bit.
  - Falling edges are ignored.
- Timer:
  - When EN=1, each cycle: if TCNT == TCMP then TCNT <= 0 and MATCH <= 1; else TCNT <= TCNT+1, wrapping modulo 2^DATA_SIZE.
  - When EN=0, TCNT holds.
  - A bus write to TCNT overrides increment/reload that cycle.
  - Hardware MATCH set wins over a same-cycle W1C.
  - Writing TCMP while running takes effect for the next comparison.
- No bus stalls or handshake beyond the strobes; the block never back-pressures.

Decomposition:
- Package gpio_pkg holds:
  - register index localparams (GPIO_LED=0, GPIO_SW=1, GPIO_EDGE=2, GPIO_TCTRL=3, GPIO_TCNT=4, GPIO_TCMP=5);
  - TCTRL bit positions (TCTRL_EN=0, TCTRL_MATCH=1).
- Sub-module input_debouncer, parameterised by width, SYNC_STAGES and DEBOUNCE_CYCLES: contains synchroniser, candidate and counter; outputs stable.
- Edge capture, timer and bus decode remain in gpio_responder.

Test Plan:
- Assert RESET mid-cycle with TCNT running -> all outputs 0 and TCMP=0xFFFFFFFF immediately, before any CLK edge.
- Write 0x2A5 to index 0, then read index 0 -> LEDR=0x2A5 after the write edge; ddata_r=0x000002A5 exactly one cycle after the read strobe.
- Set SW=0x001, hold 25 cycles, read index 1 then index 2 -> 0x001 and 0x001. Write 0x001 to index 2 -> EDGE reads 0.
- Toggle SW[3] every 5 cycles for 100 cycles (bounce), then hold 1 -> SW register never reflects bounces; exactly one EDGE[3] set.
- Write TCMP=9, then TCTRL=1 -> TCNT counts 0..9, wraps to 0 and MATCH=1 at cycle 10. Write TCTRL=0x3 -> MATCH clears, EN stays 1.
- Same-cycle stimulus: W1C of EDGE[0] coincident with a new rising edge on bit 0 -> EDGE[0] remains 1. Read and write to index 4 in the same cycle -> ddata_r returns the pre-write TCNT.
